eeprom_arb: RTL
===============

EEPROM_ARB -- requirements
Module: eeprom_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4096, meaning the number of WAIT cycles without ACK before an operation is aborted; legal range 2..65535.
REQ-002 SHALL have port CLK, input, 1 bit, the single system clock; all state changes on posedge CLK.
REQ-003 SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port A_REQ, input, 1 bit, requester A operation request (level, held until A_DONE).
REQ-005 SHALL have port A_RW, input, 1 bit, requester A operation type: 1 = read, 0 = write.
REQ-006 SHALL have port A_ADDR, input, 11 bits, requester A EEPROM byte address.
REQ-007 SHALL have port A_WDATA, input, 8 bits, requester A write data.
REQ-008 SHALL have port A_RDATA, output, 8 bits, requester A read data, valid from the A_DONE pulse until A's next grant.
REQ-009 SHALL have port A_DONE, output, 1 bit, one-cycle completion pulse for requester A.
REQ-010 SHALL have port A_ERR, output, 1 bit, timeout flag, valid only during the A_DONE pulse.
REQ-011 SHALL have ports B_REQ, B_RW, B_ADDR, B_WDATA, B_RDATA, B_DONE, B_ERR, identical to REQ-004..010 for requester B.
REQ-012 SHALL have port WR, output, 1 bit, write strobe to the EEPROM serial controller.
REQ-013 SHALL have port RD, output, 1 bit, read strobe to the EEPROM serial controller.
REQ-014 SHALL have port ADDR, output, 11 bits, address to the controller.
REQ-015 SHALL have port DATA_OUT, output, 8 bits, write data to the controller's DATA bus.
REQ-016 SHALL have port DATA_OE, output, 1 bit; when 1, the top level drives DATA_OUT onto DATA.
REQ-017 SHALL have port DATA_IN, input, 8 bits, read data from the controller's DATA bus.
REQ-018 SHALL have port ACK, input, 1 bit, end-of-operation pulse from the controller.
REQ-019 SHALL have port BUSY, output, 1 bit, high in every state except IDLE.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and DONE, encoded one-hot.
REQ-021 IDLE: when either REQ is high, SHALL grant round-robin, go to ISSUE the next cycle, and latch the winner's RW, ADDR and WDATA into internal command registers.
REQ-022 Round-robin: with both REQ high, SHALL grant the requester not served last; after reset, A wins the first tie.
REQ-023 ISSUE: SHALL assert exactly one of WR (RW=0) or RD (RW=1) for exactly one cycle, then go to WAIT; the timeout counter SHALL clear to 0.
REQ-024 ADDR and DATA_OUT SHALL hold the latched command values from ISSUE through DONE.
REQ-025 DATA_OE SHALL be 1 in ISSUE and WAIT for a write, and 0 otherwise.
REQ-026 WAIT: the counter SHALL increment each cycle.
REQ-027 WAIT on ACK=1: SHALL go to DONE with ERR=0; for a read, SHALL capture DATA_IN into the granted requester's RDATA in that same cycle.
REQ-028 WAIT timeout: when the counter equals TIMEOUT_CYC-1 with ACK=0, SHALL go to DONE with ERR=1 and leave RDATA unchanged.
REQ-029 Simultaneous ACK and timeout SHALL count as success.
REQ-030 ACK SHALL be ignored in IDLE, ISSUE and DONE.
REQ-031 DONE: SHALL pulse the granted requester's DONE for one cycle, update the last-served pointer, and return to IDLE.
REQ-032 Requester handshake: a REQ still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-033 A REQ deasserted mid-operation SHALL NOT abort the operation; the operation completes and DONE is still pulsed.
REQ-034 The counter SHALL be 16 bits wide and SHALL saturate, never wrap.

Reset
REQ-035 RESET=1 SHALL immediately force: state IDLE; WR=RD=DATA_OE=BUSY=0; A_DONE=B_DONE=A_ERR=B_ERR=0; A_RDATA=B_RDATA=8'h00; ADDR=11'h000; DATA_OUT=8'h00; counter 0; last-served pointer = B.
REQ-036 Reset asserted mid-operation SHALL abandon the operation with no DONE pulse.
REQ-037 After RESET deasserts, the first grant SHALL occur no earlier than the first posedge CLK.

Verification
REQ-038 A write: A_REQ=1, A_RW=0, A_ADDR=11'h155, A_WDATA=8'hA5; ACK after 30 cycles -> one-cycle WR, ADDR=11'h155, DATA_OUT=8'hA5 with DATA_OE=1, A_DONE pulse with A_ERR=0.
REQ-039 B read: B_RW=1, B_ADDR=11'h7FF; ACK with DATA_IN=8'h3C -> one-cycle RD, B_RDATA=8'h3C at B_DONE, DATA_OE stays 0.
REQ-040 Contention: A_REQ and B_REQ both held high continuously after reset -> grants A, B, A, B, with no back-to-back grant to the same requester.
REQ-041 Timeout: TIMEOUT_CYC=8, ACK never returned -> DONE pulse with ERR=1, 8 WAIT cycles, RDATA unchanged.
REQ-042 Reset in WAIT: RESET asserted 5 cycles into WAIT -> outputs take reset values asynchronously, no DONE pulse; a later ACK is ignored in IDLE.
REQ-043 Stray ACK: ACK pulsed while in IDLE, and in the ISSUE cycle -> no state change, no DONE pulse.

Source files
------------

// File: rtl/eeprom_arb.sv
// Two-requester round-robin arbiter in front of a serial EEPROM controller.
// One command is latched per grant, strobed once, and completed by ACK or timeout.
module eeprom_arb #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_REQ,
  input  logic        A_RW,
  input  logic [10:0] A_ADDR,
  input  logic [7:0]  A_WDATA,
  output logic [7:0]  A_RDATA,
  output logic        A_DONE,
  output logic        A_ERR,
  input  logic        B_REQ,
  input  logic        B_RW,
  input  logic [10:0] B_ADDR,
  input  logic [7:0]  B_WDATA,
  output logic [7:0]  B_RDATA,
  output logic        B_DONE,
  output logic        B_ERR,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  input  logic [7:0]  DATA_IN,
  input  logic        ACK,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, next_state;
  logic        pick_b;
  logic        grant_b;
  logic        last_b;
  logic        cmd_rw;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [15:0] cnt;
  logic        err;
  logic [7:0]  a_rdata_q;
  logic [7:0]  b_rdata_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // B wins only when A is idle or when A was the last one served.
  always_comb begin
    next_state = state;
    pick_b     = B_REQ && (!A_REQ || !last_b);
    case (state)
      S_IDLE:  if (A_REQ || B_REQ) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (ACK || (cnt == TMO_LAST)) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_b   <= 1'b0;
      last_b    <= 1'b1;
      cmd_rw    <= 1'b0;
      cmd_addr  <= 11'h000;
      cmd_wdata <= 8'h00;
      cnt       <= 16'h0000;
      err       <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (A_REQ || B_REQ) begin
            grant_b   <= pick_b;
            cmd_rw    <= pick_b ? B_RW    : A_RW;
            cmd_addr  <= pick_b ? B_ADDR  : A_ADDR;
            cmd_wdata <= pick_b ? B_WDATA : A_WDATA;
          end
        end
        S_ISSUE: cnt <= 16'h0000;
        S_WAIT: begin
          if (cnt != 16'hFFFF) cnt <= cnt + 16'h0001;
          // ACK takes priority so a coincident timeout still reports success.
          if (ACK) begin
            err <= 1'b0;
            if (cmd_rw) begin
              if (grant_b) b_rdata_q <= DATA_IN;
              else         a_rdata_q <= DATA_IN;
            end
          end else if (cnt == TMO_LAST) begin
            err <= 1'b1;
          end
        end
        S_DONE: last_b <= grant_b;
        default: ;
      endcase
    end
  end

  assign WR       = (state == S_ISSUE) && !cmd_rw;
  assign RD       = (state == S_ISSUE) && cmd_rw;
  assign DATA_OE  = ((state == S_ISSUE) || (state == S_WAIT)) && !cmd_rw;
  assign ADDR     = cmd_addr;
  assign DATA_OUT = cmd_wdata;
  assign BUSY     = (state != S_IDLE);
  assign A_DONE   = (state == S_DONE) && !grant_b;
  assign B_DONE   = (state == S_DONE) && grant_b;
  assign A_ERR    = A_DONE && err;
  assign B_ERR    = B_DONE && err;
  assign A_RDATA  = a_rdata_q;
  assign B_RDATA  = b_rdata_q;

endmodule
